// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add computed one nibble per clock through a shared 4-bit adder.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN (adds the sub input).
`default_nettype none

module bits4adder (
  input  logic [3:0] ip1,
  input  logic [3:0] ip2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, ip1} + {1'b0, ip2} + {4'b0000, cin};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [3:0]       nib_sum;
  logic             nib_cout;

  // Operand latch values; subtract mode feeds ~op_b with a forced carry-in of 1.
  logic [WIDTH-1:0] b_load;
  logic             c_load;
`ifdef NIBBLE_SERIAL_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1  : cin;
`else
  assign b_load = op_b;
  assign c_load = cin;
`endif

  bits4adder u_adder (
    .ip1  (a_sh[3:0]),
    .ip2  (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= op_a;
            b_sh   <= b_load;
            carry  <= c_load;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Sum nibbles enter at the top so the LS nibble lands at bit 0 after NIB shifts.
          result <= {nib_sum, result[WIDTH-1:4]};
          a_sh   <= {4'b0000, a_sh[WIDTH-1:4]};
          b_sh   <= {4'b0000, b_sh[WIDTH-1:4]};
          carry  <= nib_cout;
          if (idx == LAST_IDX) begin
            cout  <= nib_cout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
